sobel_edge_detect: RTL and testbench

Streaming 3x3 Sobel edge detector that sits directly upstream of the VGA display path. It consumes an 8-bit grayscale pixel stream with DE/HS/VS timing and produces the 1-bit edge stream, `oSobel`, with matching delayed syncs. The VGA controller displays `oSobel` as white (1) or black (0). One pixel per clock, no back-pressure, two internal line buffers.

---
 rtl/sobel_edge_detect_pkg.sv | 46 ++++
 rtl/sobel_edge_detect_if.sv | 16 +
 rtl/sobel_edge_detect_line_buffer.sv | 30 +++
 rtl/sobel_edge_detect.sv | 97 +++++++++
 tb/tb_sobel_edge_detect.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/sobel_edge_detect_pkg.sv
// Shared widths, kernel coefficients and small arithmetic helpers for the
// streaming Sobel edge detector.
package sobel_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;
  localparam int MAG_W  = 11;
  localparam int LAT    = 3;

  // Sobel kernel weights: outer taps and centre tap of each 3-tap column/row.
  localparam logic [GRAD_W-1:0] K_SIDE = GRAD_W'(1);
  localparam logic [GRAD_W-1:0] K_CTR  = GRAD_W'(2);

  // win[r][c]: r=0 top row (oldest line), c=0 left column (oldest pixel).
  typedef logic [2:0][2:0][PIX_W-1:0] window_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

  // Weighted 3-tap difference (a-side minus b-side); fits in GRAD_W signed.
  function automatic logic signed [GRAD_W-1:0] grad(
    input logic [PIX_W-1:0] a0, a1, a2,
    input logic [PIX_W-1:0] b0, b1, b2
  );
    logic [GRAD_W-1:0] pos, neg;
    pos = K_SIDE * GRAD_W'(a0) + K_CTR * GRAD_W'(a1) + K_SIDE * GRAD_W'(a2);
    neg = K_SIDE * GRAD_W'(b0) + K_CTR * GRAD_W'(b1) + K_SIDE * GRAD_W'(b2);
    return $signed(pos - neg);
  endfunction

  function automatic logic [MAG_W-1:0] grad_mag(
    input logic signed [GRAD_W-1:0] gx,
    input logic signed [GRAD_W-1:0] gy
  );
    logic [MAG_W-1:0] ax, ay;
    ax = gx[GRAD_W-1] ? MAG_W'(-gx) : MAG_W'(gx);
    ay = gy[GRAD_W-1] ? MAG_W'(-gy) : MAG_W'(gy);
    return ax + ay;
  endfunction

endpackage

// File: rtl/sobel_edge_detect_if.sv
// Pixel stream in (gray + DE/HS/VS) and edge stream out with delayed syncs.
interface sobel_edge_detect_if;
  import sobel_pkg::*;

  logic [PIX_W-1:0] iGray;
  logic             iDE;
  logic             iHS;
  logic             iVS;
  logic             oSobel;
  logic             oDE;
  logic             oHS;
  logic             oVS;

  modport master (output iGray, iDE, iHS, iVS, input oSobel, oDE, oHS, oVS);
  modport slave  (input iGray, iDE, iHS, iVS, output oSobel, oDE, oHS, oVS);
endinterface

// File: rtl/sobel_edge_detect_line_buffer.sv
// Two stacked line stores sharing one address: combinational read of both,
// and on write the row-1 entry slides down into row-2 as the new pixel lands.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] row1,
  output logic [PIX_W-1:0] row2
);

  logic [PIX_W-1:0] lb1 [DEPTH];
  logic [PIX_W-1:0] lb2 [DEPTH];

  assign row1 = lb1[addr];
  assign row2 = lb2[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      lb2[addr] <= lb1[addr];
      lb1[addr] <= din;
    end
  end

endmodule

// File: rtl/sobel_edge_detect.sv
// 3x3 Sobel edge detector: column/row tracking, window, 3-stage gradient
// pipeline and matching sync delay lines. One pixel per clock, no stall.
module sobel_edge_detect
  import sobel_pkg::*;
#(
  parameter int               IMG_WIDTH = 640,
  parameter logic [MAG_W-1:0] THRESHOLD = 11'd200
) (
  input  logic                iCLK,
  input  logic                rst,
  sobel_edge_detect_if.slave  bus
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [10:0] COL_MAX = 11'(IMG_WIDTH);

  logic [10:0]      col, row;
  logic             de_q;
  logic             synced;
  logic             accept;
  logic [AW-1:0]    addr;
  logic [PIX_W-1:0] up1, up2;

  window_t                  win;
  logic [2:1]               vld_pipe;
  logic signed [GRAD_W-1:0] gx, gy;
  logic                     sobel_q;
  sync_t [LAT-1:0]          dly;
  sync_t                    cur;

  assign accept = bus.iDE && (col < COL_MAX);
  assign addr   = accept ? col[AW-1:0] : '0;
  assign cur    = '{de: bus.iDE, hs: bus.iHS, vs: bus.iVS};

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .AW(AW)) u_lb (
    .clk  (iCLK),
    .we   (accept),
    .addr (addr),
    .din  (bus.iGray),
    .row1 (up1),
    .row2 (up2)
  );

  // synced stays low after reset until a VS pulse, so a frame cut in half
  // by reset never exposes mis-aligned columns.
  always_ff @(posedge iCLK) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      de_q   <= 1'b0;
      synced <= 1'b0;
    end else begin
      de_q <= bus.iDE;
      if (!bus.iVS) synced <= 1'b1;
      if (!bus.iDE) col <= '0;
      else if (col < COL_MAX) col <= col + 11'd1;
      if (!bus.iVS) row <= '0;
      else if (de_q && !bus.iDE && row != 11'h7FF) row <= row + 11'd1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (rst) begin
      win      <= '0;
      vld_pipe <= '0;
      gx       <= '0;
      gy       <= '0;
      sobel_q  <= 1'b0;
      dly      <= {LAT{SYNC_IDLE}};
    end else begin
      // stage 1: shift window, evaluate border mask
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= up2;
        win[1][2] <= up1;
        win[2][2] <= bus.iGray;
      end
      vld_pipe[1] <= accept && synced && (row >= 11'd2) && (col >= 11'd2);
      // stage 2: gradients
      gx <= grad(win[0][2], win[1][2], win[2][2], win[0][0], win[1][0], win[2][0]);
      gy <= grad(win[2][0], win[2][1], win[2][2], win[0][0], win[0][1], win[0][2]);
      vld_pipe[2] <= vld_pipe[1];
      // stage 3: threshold
      sobel_q <= vld_pipe[2] && (grad_mag(gx, gy) > THRESHOLD);
      dly <= {dly[LAT-2:0], cur};
    end
  end

  assign bus.oSobel = sobel_q;
  assign bus.oDE    = dly[LAT-1].de;
  assign bus.oHS    = dly[LAT-1].hs;
  assign bus.oVS    = dly[LAT-1].vs;

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Directed frame-level bench with a scoreboard queue and an image model
// that computes Sobel directly from the stimulus frame.
module tb_sobel_edge_detect;

  localparam int W  = 32;
  localparam int TH = 200;

  typedef struct {
    logic sob;
    logic de;
    logic hs;
    logic vs;
  } exp_t;

  localparam exp_t RST = '{sob: 1'b0, de: 1'b0, hs: 1'b1, vs: 1'b1};

  logic clk = 1'b0;
  logic rst;
  sobel_edge_detect_if bus();

  sobel_edge_detect #(.IMG_WIDTH(W), .THRESHOLD(11'd200)) dut (
    .iCLK (clk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] img [0:31][0:39];
  int         len [0:31];
  bit         tb_synced;
  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_edge(input int r, input int c);
    int p [3][3];
    int gx, gy, m;
    if (!tb_synced || r < 2 || c < 2 || c >= W) return 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = int'(img[r-2+i][c-2+j]);
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > TH);
  endfunction

  // Drive one cycle, record what the output must be two edges later,
  // and compare the entry that is due now.
  task automatic cycle(input logic [7:0] g, input logic d, input logic h,
                       input logic v, input logic r, input logic e);
    exp_t x, o;
    bus.iGray = g; bus.iDE = d; bus.iHS = h; bus.iVS = v; rst = r;
    @(posedge clk); #1;
    if (r) begin
      q.delete();
      q.push_back(RST);
      q.push_back(RST);
      x = RST;
      tb_synced = 1'b0;
    end else begin
      x = '{sob: e, de: d, hs: h, vs: v};
      if (!v) tb_synced = 1'b1;
    end
    q.push_back(x);
    if (q.size() == 3) begin
      o = q.pop_front();
      chk("sobel", bus.oSobel, o.sob);
      chk("de",    bus.oDE,    o.de);
      chk("hs",    bus.oHS,    o.hs);
      chk("vs",    bus.oVS,    o.vs);
    end
  endtask

  // rr/rc place a 5-cycle reset inside line rr starting at pixel rc (-1: none).
  task automatic frame(input int h, input int rr, input int rc);
    logic rs, e;
    for (int i = 0; i < 4; i++) cycle(8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(8'($urandom), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < len[r]; c++) begin
        rs = (r == rr) && (c >= rc) && (c < rc + 5);
        e  = rs ? 1'b0 : exp_edge(r, c);
        cycle(img[r][c], 1'b1, 1'b1, 1'b1, rs, e);
      end
      for (int b = 0; b < 8; b++)
        cycle(8'($urandom), 1'b0, !(b >= 2 && b < 5), 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < 32; r++) begin
      len[r] = 30;
      for (int c = 0; c < 40; c++)
        case (mode)
          0:       img[r][c] = 8'h80;
          1:       img[r][c] = (c < 15) ? 8'h00 : 8'hFF;
          2:       img[r][c] = 8'h00;
          default: img[r][c] = 8'($urandom);
        endcase
    end
  endtask

  initial begin
    tb_synced = 1'b0;
    bus.iGray = '0; bus.iDE = 1'b0; bus.iHS = 1'b1; bus.iVS = 1'b1; rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // flat field
    fill(0);
    frame(30, -1, -1);

    // vertical step, then the same frame with a reset in the middle of a line
    fill(1);
    frame(30, -1, -1);
    frame(30, 10, 12);
    frame(30, -1, -1);

    // isolated pixels: magnitude peaks of exactly 200 and of 202
    fill(2);
    img[5][5]  = 8'd100;
    img[5][20] = 8'd101;
    frame(12, -1, -1);

    // random frame followed by a flat one
    fill(3);
    frame(30, -1, -1);
    fill(0);
    frame(30, -1, -1);

    // over-long lines, then normal lines, then a 2-pixel line
    fill(3);
    for (int r = 0; r < 4; r++) len[r] = W + 5;
    len[6] = 2;
    frame(7, -1, -1);

    for (int i = 0; i < 4; i++) cycle(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
